// File: rtl/ysyx_22040632_mem_arbiter_if.sv
// ysyx_22040632_mem_arbiter_if: IF/MEM request channels, downstream port and owner bundle.
// Modport slave is the arbiter's view; master is the requesters/downstream view.
interface ysyx_22040632_mem_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [2:0]  i_size;
    logic [63:0] i_rdata;
    logic        d_valid;
    logic        d_ready;
    logic        d_req;
    logic [31:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_wmask;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic        m_ready;
    logic        m_req;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_wmask;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic [1:0]  owner;
    modport slave (
        input  i_valid, i_addr, i_size, d_valid, d_req, d_addr, d_size, d_wmask, d_wdata, m_ready, m_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, m_valid, m_req, m_addr, m_size, m_wmask, m_wdata, owner
    );
    modport master (
        output i_valid, i_addr, i_size, d_valid, d_req, d_addr, d_size, d_wmask, d_wdata, m_ready, m_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, m_valid, m_req, m_addr, m_size, m_wmask, m_wdata, owner
    );
endinterface

// File: rtl/ysyx_22040632_mem_arbiter.sv
// ysyx_22040632_mem_arbiter: D-over-I arbiter for the shared memory port.
// Define YSYX_22040632_ARB_STARVE_EN to force an I grant after STARVE_MAX D grants while I waits.
module ysyx_22040632_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rrst,
    ysyx_22040632_mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [1:0] owner;
    logic pick_i;
    logic own_i;
    logic own_d;
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end
`ifdef YSYX_22040632_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    assign pick_i = bus.i_valid && (!bus.d_valid || starve_cnt == 4'(STARVE_MAX));
    // Counts D grants that bypassed a waiting I; saturates so the force stays armed.
    always_ff @(posedge clk) begin
        if (rrst)
            starve_cnt <= 4'd0;
        else if (state == IDLE && (bus.i_valid || bus.d_valid))
            starve_cnt <= pick_i ? 4'd0 :
                          (bus.i_valid && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
    end
`else
    assign pick_i = bus.i_valid && !bus.d_valid;
`endif
    always_ff @(posedge clk) begin
        if (rrst) begin
            state <= IDLE;
            owner <= 2'b00;
        end else if (state == IDLE) begin
            if (bus.i_valid || bus.d_valid) begin
                state <= BUSY;
                owner <= pick_i ? 2'b01 : 2'b10;
            end
        end else if (bus.m_ready) begin
            state <= IDLE;
            owner <= 2'b00;
        end
    end
    assign own_i       = owner == 2'b01;
    assign own_d       = owner == 2'b10;
    assign bus.owner   = owner;
    assign bus.m_valid = state == BUSY;
    assign bus.m_req   = own_d & bus.d_req;
    assign bus.m_addr  = own_i ? bus.i_addr : own_d ? bus.d_addr : 32'd0;
    assign bus.m_size  = own_i ? bus.i_size : own_d ? bus.d_size : 3'd0;
    assign bus.m_wmask = own_d ? bus.d_wmask : 8'd0;
    assign bus.m_wdata = own_d ? bus.d_wdata : 64'd0;
    assign bus.i_ready = own_i & bus.m_ready;
    assign bus.d_ready = own_d & bus.m_ready;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;
endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
// tb_ysyx_22040632_mem_arbiter: directed scenarios for the memory arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ysyx_22040632_mem_arbiter;
    logic clk = 1'b0;
    logic rrst;
    int vectors = 0;
    int errors = 0;
`ifdef YSYX_22040632_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    ysyx_22040632_mem_arbiter_if bus();
    ysyx_22040632_mem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rrst(rrst), .bus(bus));
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_valid = 0; bus.i_addr = 0; bus.i_size = 0;
        bus.d_valid = 0; bus.d_req = 0; bus.d_addr = 0; bus.d_size = 0; bus.d_wmask = 0; bus.d_wdata = 0;
        bus.m_ready = 0; bus.m_rdata = 0;
    endtask

    task automatic test_reset();
        rrst = 1; clear_inputs();
        cyc(); cyc();
        rrst = 0;
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst0_m_valid got=%b exp=0", bus.m_valid); end
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rst0_owner got=%b exp=00", bus.owner); end
        bus.d_valid = 1; bus.d_addr = 32'h8000_0040; bus.d_size = 3;
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", bus.m_valid); end
        rrst = 1; bus.d_valid = 0;
        cyc(); cyc();
        rrst = 0; bus.m_ready = 1;
        #1;
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rst_owner got=%b exp=00", bus.owner); end
        vectors++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {bus.i_ready, bus.d_ready}); end
        vectors++; if (bus.m_addr !== 32'd0) begin errors++; $display("FAIL rst_m_addr got=%h exp=0", bus.m_addr); end
        cyc(); bus.m_ready = 0;
    endtask

    task automatic test_d_write();
        bus.d_valid = 1; bus.d_req = 1; bus.d_addr = 32'h8000_0010; bus.d_size = 3'd2;
        bus.d_wmask = 8'h0F; bus.d_wdata = 64'h1234_5678;
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL wr_m_valid got=%b exp=1", bus.m_valid); end
        vectors++; if (bus.owner !== 2'b10) begin errors++; $display("FAIL wr_owner got=%b exp=10", bus.owner); end
        vectors++; if (bus.m_req !== 1'b1) begin errors++; $display("FAIL wr_m_req got=%b exp=1", bus.m_req); end
        vectors++; if (bus.m_addr !== 32'h8000_0010) begin errors++; $display("FAIL wr_m_addr got=%h exp=80000010", bus.m_addr); end
        vectors++; if (bus.m_size !== 3'd2) begin errors++; $display("FAIL wr_m_size got=%0d exp=2", bus.m_size); end
        vectors++; if (bus.m_wmask !== 8'h0F) begin errors++; $display("FAIL wr_m_wmask got=%h exp=0f", bus.m_wmask); end
        vectors++; if (bus.m_wdata !== 64'h1234_5678) begin errors++; $display("FAIL wr_m_wdata got=%h exp=12345678", bus.m_wdata); end
        vectors++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL wr_early_ready got=%b exp=0", bus.d_ready); end
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL wr_hold_valid got=%b exp=1", bus.m_valid); end
        cyc(); bus.m_ready = 1; bus.m_rdata = 64'h5555_AAAA_0000_0001; #1;
        vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL wr_d_ready got=%b exp=1", bus.d_ready); end
        vectors++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL wr_i_ready got=%b exp=0", bus.i_ready); end
        vectors++; if (bus.d_rdata !== 64'h5555_AAAA_0000_0001) begin errors++; $display("FAIL wr_d_rdata got=%h exp=5555aaaa00000001", bus.d_rdata); end
        cyc(); bus.m_ready = 0; bus.d_valid = 0; #1;
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL wr_idle_valid got=%b exp=0", bus.m_valid); end
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL wr_idle_owner got=%b exp=00", bus.owner); end
    endtask

    task automatic test_i_read();
        bus.d_req = 1; bus.d_wmask = 8'hFF; bus.d_wdata = 64'hFFFF_0000_FFFF_0000;
        bus.i_valid = 1; bus.i_addr = 32'h8000_0000; bus.i_size = 3'd2;
        cyc(); #1;
        vectors++; if (bus.owner !== 2'b01) begin errors++; $display("FAIL rd_owner got=%b exp=01", bus.owner); end
        vectors++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL rd_m_req got=%b exp=0", bus.m_req); end
        vectors++; if (bus.m_wmask !== 8'h00) begin errors++; $display("FAIL rd_m_wmask got=%h exp=00", bus.m_wmask); end
        vectors++; if (bus.m_wdata !== 64'd0) begin errors++; $display("FAIL rd_m_wdata got=%h exp=0", bus.m_wdata); end
        vectors++; if (bus.m_addr !== 32'h8000_0000) begin errors++; $display("FAIL rd_m_addr got=%h exp=80000000", bus.m_addr); end
        cyc(); bus.m_ready = 1; bus.m_rdata = 64'hDEAD_BEEF_0000_0013; #1;
        vectors++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL rd_i_ready got=%b exp=1", bus.i_ready); end
        vectors++; if (bus.i_rdata !== 64'hDEAD_BEEF_0000_0013) begin errors++; $display("FAIL rd_i_rdata got=%h exp=deadbeef00000013", bus.i_rdata); end
        vectors++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rd_d_ready got=%b exp=0", bus.d_ready); end
        vectors++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL rd_m_req_end got=%b exp=0", bus.m_req); end
        cyc(); bus.m_ready = 0; bus.i_valid = 0; #1;
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rd_idle_owner got=%b exp=00", bus.owner); end
    endtask

    task automatic test_contention();
        bus.i_valid = 1; bus.d_valid = 1; bus.d_addr = 32'h8000_0100;
        cyc(); #1;
        vectors++; if (bus.owner !== 2'b10) begin errors++; $display("FAIL ct_first got=%b exp=10", bus.owner); end
        bus.m_ready = 1; #1;
        vectors++; if ({bus.i_ready, bus.d_ready} !== 2'b01) begin errors++; $display("FAIL ct_d_ready got=%b exp=01", {bus.i_ready, bus.d_ready}); end
        cyc(); bus.m_ready = 0; bus.d_valid = 0; #1;
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL ct_gap got=%b exp=00", bus.owner); end
        cyc(); #1;
        vectors++; if (bus.owner !== 2'b01) begin errors++; $display("FAIL ct_second got=%b exp=01", bus.owner); end
        bus.m_ready = 1; #1;
        vectors++; if ({bus.i_ready, bus.d_ready} !== 2'b10) begin errors++; $display("FAIL ct_i_ready got=%b exp=10", {bus.i_ready, bus.d_ready}); end
        cyc(); bus.m_ready = 0; bus.i_valid = 0;
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        bus.i_valid = 1; bus.d_valid = 1;
        for (int g = 0; g < 6; g++) begin
            exp = (STARVE && g == 4) ? 2'b01 : 2'b10;
            cyc(); #1;
            vectors++; if (bus.owner !== exp) begin errors++; $display("FAIL sv_grant%0d got=%b exp=%b", g, bus.owner, exp); end
            bus.m_ready = 1; #1;
            vectors++; if ({bus.i_ready, bus.d_ready} !== {exp[0], exp[1]}) begin errors++; $display("FAIL sv_ready%0d got=%b exp=%b", g, {bus.i_ready, bus.d_ready}, {exp[0], exp[1]}); end
            cyc(); bus.m_ready = 0; #1;
            vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL sv_gap%0d got=%b exp=0", g, bus.m_valid); end
        end
        bus.i_valid = 0; bus.d_valid = 0;
        cyc();
    endtask

    task automatic test_dropped_valid();
        bus.d_valid = 1; bus.d_req = 1; bus.d_addr = 32'h8000_0200;
        cyc(); bus.d_valid = 0; #1;
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL dv_valid got=%b exp=1", bus.m_valid); end
        vectors++; if (bus.owner !== 2'b10) begin errors++; $display("FAIL dv_owner got=%b exp=10", bus.owner); end
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL dv_hold got=%b exp=1", bus.m_valid); end
        bus.m_ready = 1; #1;
        vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL dv_ready got=%b exp=1", bus.d_ready); end
        cyc(); bus.m_ready = 0; #1;
        vectors++; if ({bus.m_valid, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL dv_done got=%b exp=00", {bus.m_valid, bus.d_ready}); end
        cyc(); #1;
        vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL dv_no_regrant got=%b exp=00", bus.owner); end
    endtask

    task automatic test_idle_mready();
        bus.m_ready = 1; #1;
        vectors++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL im_ready got=%b exp=00", {bus.i_ready, bus.d_ready}); end
        cyc(); #1;
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL im_valid got=%b exp=0", bus.m_valid); end
        bus.m_ready = 0;
    endtask

    initial begin
        test_reset();
        test_d_write();
        test_i_read();
        test_contention();
        test_starvation();
        test_dropped_valid();
        test_idle_mready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040632_mem_arbiter.md
# ysyx_22040632_mem_arbiter

Two-requester arbiter sharing the single data-cache/AXI master port between the instruction-fetch path (I, read-only) and the memory stage (D, read/write). Sits between the IF/MEM request channels and the downstream port. One request is granted at a time; the grant is held until the downstream handshake completes. Fixed D-over-I priority, with an optional starvation guard for I.

## Interface
- STARVE_MAX, 4: number of consecutive D grants while I waits before I is forced; range 1..15.
- clk  in  1  clock.
- rrst  in  1  synchronous, active-high reset.
- i_valid  in  1  I request pending; held high until i_ready.
- i_ready  out  1  I transaction complete this cycle.
- i_addr  in  32  I address.
- i_size  in  3  I AXI burst size code.
- i_rdata  out  64  read data to I; valid only with i_ready.
- d_valid  in  1  D request pending; held high until d_ready.
- d_ready  out  1  D transaction complete this cycle.
- d_req  in  1  REQ_READ / REQ_WRITE.
- d_addr  in  32  D address.
- d_size  in  3  D AXI burst size code.
- d_wmask  in  8  D byte write mask.
- d_wdata  in  64  D write data, lane-aligned.
- d_rdata  out  64  read data to D; valid only with d_ready.
- m_valid  out  1  downstream request valid.
- m_ready  in  1  downstream completion, one-cycle pulse.
- m_req, m_addr, m_size, m_wmask, m_wdata  out  1/32/3/8/64  downstream request fields.
- m_rdata  in  64  downstream read data, valid with m_ready.
- owner  out  2  00 none, 01 I, 10 D.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any valid, select a winner, latch it in owner, go to BUSY. Otherwise stay in IDLE.
- Winner selection: D wins over I. Exception: when the starvation guard fires, I wins.
- BUSY: m_valid=1. The m_* fields are muxed from the owner's inputs. I forces m_req=REQ_READ, m_wmask=0, m_wdata=0.
- BUSY exit: on m_ready, pulse the owner's ready combinationally in the same cycle and go to IDLE. Owner clears at the same edge.
- Read data: i_rdata = d_rdata = m_rdata, passed straight through. Each is qualified by its own ready.
- When no owner: m_* fields are 0, m_valid=0, both readys are 0.
- Requester rules:
  - A requester must hold valid and its fields stable until its ready.
  - A valid dropped while owned is ignored; the transaction completes and ready still pulses.
- Non-owner valid during BUSY waits. It is never lost.
- Reset: on rrst in any state, go to IDLE, owner=0, starve_cnt=0. An in-flight transaction is abandoned; the downstream port is reset by the same rrst.
- Reset values of all outputs: m_valid 0, i_ready 0, d_ready 0, owner 0, all m_* fields 0, rdata passthrough.

## Timing
- Grant latency: valid seen at edge N in IDLE gives m_valid=1 from cycle N+1.
- Ready latency: the requester's ready is asserted in the same cycle as m_ready.
- Minimum occupancy is 2 cycles per transaction (BUSY with same-cycle m_ready, then one IDLE cycle). No back-to-back grant without an IDLE cycle.
- Simultaneous i_valid and d_valid in IDLE: D granted unless the starvation guard fires.
- m_ready while in IDLE is ignored.

## Configuration
- YSYX_22040632_ARB_STARVE_EN defined: a 4-bit starve_cnt is implemented.
  - It increments, saturating at STARVE_MAX, on each D grant made while i_valid=1.
  - It clears to 0 on any I grant.
  - In IDLE with starve_cnt==STARVE_MAX and i_valid=1, I is granted even if d_valid=1.
- Undefined: strict D priority with no counter. I can starve indefinitely.

## Test plan
- Reset: assert rrst for 2 cycles during BUSY -> next cycle m_valid=0, owner=00, i_ready=d_ready=0.
- Single D write: d_valid=1, d_req=WRITE, d_addr=0x8000_0010, d_wmask=0x0F, d_wdata=0x1234_5678.
  - m_valid and matching fields at N+1, owner=10.
  - m_ready at N+3 -> d_ready at N+3, IDLE at N+4.
- Single I read: i_valid, i_addr=0x8000_0000, m_rdata=0xDEAD_BEEF_0000_0013 with m_ready.
  - i_ready with i_rdata=0xDEAD_BEEF_0000_0013 in the same cycle.
  - m_req=READ and m_wmask=0 throughout.
- Contention: i_valid and d_valid both raised in the same cycle -> D served first, I granted the IDLE cycle after d_ready, no lost request.
- Starvation (macro on, STARVE_MAX=4): d_valid held continuously with i_valid high -> 4 D grants, then the 5th grant goes to I, then D resumes.
  - Macro off: I is never granted while d_valid stays high.
- Dropped valid: d_valid deasserted mid-BUSY -> m_valid stays 1 until m_ready, d_ready still pulses once.
